// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: XNOR Fibonacci LFSR with a request/acknowledge rejection-sampling draw engine.
// Optional LFSR_LOCK_RECOVER_EN: all-ones loads/states are replaced by SEED and LockErr pulses.
`timescale 1ns/1ps
`default_nettype none

module lfsr_rand_gen #(
  parameter int               WIDTH     = 9,
  parameter logic [WIDTH-1:0] TAPS      = 9'h110,
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int               OUT_W     = 2,
  parameter int               RANGE     = 4,
  parameter int               MAX_TRIES = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] SeedIn,
  input  logic             Req,
  output logic             Ack,
  output logic [OUT_W-1:0] Value,
  output logic             Miss,
  output logic             Busy,
  output logic [WIDTH-1:0] Q,
  output logic             LockErr
);

  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
  // One extra bit so RANGE == 2**OUT_W (accept everything) is representable.
  localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [TRY_W-1:0] tries;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] step_val;
  logic [OUT_W-1:0] cand;
  logic [OUT_W-1:0] value_r;
  logic             miss_r;
  logic             fb;
  logic             accept;
  logic             do_step;

  assign fb       = ~^(lfsr & TAPS);
  assign step_val = {lfsr[WIDTH-2:0], fb};
  assign cand     = lfsr[OUT_W-1:0];
  assign accept   = ({1'b0, cand} < RANGE_X);
  assign do_step  = (state == S_DRAW) || En;

`ifdef LFSR_LOCK_RECOVER_EN
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  logic lock_err_r;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lfsr       <= SEED;
      lock_err_r <= 1'b0;
    end else begin
      lock_err_r <= 1'b0;
      if (Load) begin
        if (SeedIn == ALL_ONES) begin
          lfsr       <= SEED;
          lock_err_r <= 1'b1;
        end else begin
          lfsr <= SeedIn;
        end
      end else if (lfsr == ALL_ONES) begin
        lfsr       <= SEED;
        lock_err_r <= 1'b1;
      end else if (do_step) begin
        lfsr <= step_val;
      end
    end
  end

  assign LockErr = lock_err_r;
`else
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      lfsr <= SEED;
    end else if (Load) begin
      lfsr <= SeedIn;
    end else if (do_step) begin
      lfsr <= step_val;
    end
  end

  assign LockErr = 1'b0;
`endif

  // Candidate is always taken from the pre-edge Q, so a same-cycle Load never affects it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      tries   <= '0;
      value_r <= '0;
      miss_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req) begin
            state <= S_DRAW;
            tries <= '0;
          end
        end
        S_DRAW: begin
          if (accept) begin
            value_r <= cand;
            miss_r  <= 1'b0;
            state   <= S_DONE;
          end else if (tries == LAST_TRY) begin
            value_r <= '0;
            miss_r  <= 1'b1;
            state   <= S_DONE;
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Ack   = (state == S_DONE);
  assign Busy  = (state == S_DRAW);
  assign Value = value_r;
  assign Miss  = miss_r;
  assign Q     = lfsr;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: three configurations (default, RANGE=3, RANGE=3/MAX_TRIES=2) checked
// against a transaction-level draw model; tasks start and end on a negedge in an idle cycle.
`timescale 1ns/1ps
`default_nettype none

module tb_lfsr_rand_gen;

  logic       clk = 1'b0;
  logic       rst      [3];
  logic       en       [3];
  logic       load     [3];
  logic       req      [3];
  logic [8:0] seed_in  [3];
  logic       ack      [3];
  logic       miss     [3];
  logic       busy     [3];
  logic       lock_err [3];
  logic [1:0] value    [3];
  logic [8:0] q        [3];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         rng_range [3] = '{4, 3, 3};
  int         max_tries [3] = '{8, 8, 2};
  logic [8:0] mq        [3];
  logic [1:0] last_val  [3];

  always #5 clk = ~clk;

  lfsr_rand_gen d0 (
    .Clock(clk), .Reset(rst[0]), .En(en[0]), .Load(load[0]), .SeedIn(seed_in[0]), .Req(req[0]),
    .Ack(ack[0]), .Value(value[0]), .Miss(miss[0]), .Busy(busy[0]), .Q(q[0]), .LockErr(lock_err[0])
  );

  lfsr_rand_gen #(.RANGE(3)) d1 (
    .Clock(clk), .Reset(rst[1]), .En(en[1]), .Load(load[1]), .SeedIn(seed_in[1]), .Req(req[1]),
    .Ack(ack[1]), .Value(value[1]), .Miss(miss[1]), .Busy(busy[1]), .Q(q[1]), .LockErr(lock_err[1])
  );

  lfsr_rand_gen #(.RANGE(3), .MAX_TRIES(2)) d2 (
    .Clock(clk), .Reset(rst[2]), .En(en[2]), .Load(load[2]), .SeedIn(seed_in[2]), .Req(req[2]),
    .Ack(ack[2]), .Value(value[2]), .Miss(miss[2]), .Busy(busy[2]), .Q(q[2]), .LockErr(lock_err[2])
  );

  task automatic check(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [d%0d]: got 0x%0h, expected 0x%0h at %0t", tag, idx, got, exp, $time);
    end
  endtask

  // Shift left, feed back 1 when an even number of tapped bits (Q[8], Q[4]) are set.
  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    int ones;
    ones = (s[8] ? 1 : 0) + (s[4] ? 1 : 0);
    return 9'(((s * 2) % 512) + ((ones % 2 == 0) ? 1 : 0));
  endfunction

  task automatic do_reset(input int idx);
    en[idx] = 1'b0; load[idx] = 1'b0; req[idx] = 1'b0;
    rst[idx] = 1'b1;
    #2 rst[idx] = 1'b0;
    @(negedge clk);
    mq[idx] = 9'h000; last_val[idx] = 2'd0;
    check("rst_q", idx, q[idx], 9'h000);
    check("rst_ack", idx, ack[idx], 0);
    check("rst_busy", idx, busy[idx], 0);
    check("rst_value", idx, value[idx], 0);
    check("rst_miss", idx, miss[idx], 0);
    check("rst_lockerr", idx, lock_err[idx], 0);
  endtask

  task automatic load_seed(input int idx, input logic [8:0] s);
    load[idx] = 1'b1; seed_in[idx] = s;
    @(negedge clk);
    load[idx] = 1'b0;
    mq[idx] = s;
    check("load_q", idx, q[idx], mq[idx]);
  endtask

  task automatic run_free(input int idx, input int n);
    for (int i = 0; i < n; i++) begin
      logic       e, l;
      logic [8:0] s;
      e = 1'($urandom % 2);
      l = ($urandom % 8 == 0);
      s = 9'($urandom % 511);
      en[idx] = e; load[idx] = l; seed_in[idx] = s; req[idx] = 1'b0;
      @(negedge clk);
      load[idx] = 1'b0;
      if (l) mq[idx] = s;
      else if (e) mq[idx] = lfsr_next(mq[idx]);
      check("free_q", idx, q[idx], mq[idx]);
      check("free_ack", idx, ack[idx], 0);
      check("free_busy", idx, busy[idx], 0);
      check("free_value_hold", idx, value[idx], last_val[idx]);
      check("free_lockerr", idx, lock_err[idx], 0);
    end
    en[idx] = 1'b0;
  endtask

  // One draw: predicts candidate per edge, the edge of Ack, Value, Miss and final Q.
  task automatic run_draw(input int idx, input logic en_s, input int ldk, input logic [8:0] ld_seed,
                          input logic hold, output logic [1:0] v, output logic m);
    int cand;
    check("pre_busy", idx, busy[idx], 0);
    req[idx] = 1'b1; en[idx] = en_s; load[idx] = 1'b0;
    @(negedge clk);
    if (en_s) mq[idx] = lfsr_next(mq[idx]);
    if (!hold) req[idx] = 1'b0;
    en[idx] = 1'b0;
    v = 2'd0; m = 1'b0;
    for (int k = 0; k < max_tries[idx]; k++) begin
      check("draw_busy", idx, busy[idx], 1);
      check("draw_ack_early", idx, ack[idx], 0);
      load[idx] = (k == ldk); seed_in[idx] = ld_seed;
      cand = int'(mq[idx] % 4);
      @(negedge clk);
      load[idx] = 1'b0;
      mq[idx] = (k == ldk) ? ld_seed : lfsr_next(mq[idx]);
      if (cand < rng_range[idx]) begin
        v = 2'(cand); m = 1'b0;
        break;
      end
      if (k == max_tries[idx] - 1) begin
        v = 2'd0; m = 1'b1;
      end
    end
    check("ack", idx, ack[idx], 1);
    check("ack_busy", idx, busy[idx], 0);
    check("value", idx, value[idx], v);
    check("miss", idx, miss[idx], m);
    check("draw_q", idx, q[idx], mq[idx]);
    last_val[idx] = v;
    @(negedge clk);
    check("ack_pulse", idx, ack[idx], 0);
    check("post_busy", idx, busy[idx], 0);
    check("post_q", idx, q[idx], mq[idx]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] v;
    logic       m;
    bit         seen [512];

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; load[i] = 1'b0; req[i] = 1'b0; seed_in[i] = 9'h000;
      mq[i] = 9'h000; last_val[i] = 2'd0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) do_reset(i);

    // Free-run sequence and full period from SEED.
    begin
      logic [8:0] first [6];
      first = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F, 9'h03E};
      for (int i = 0; i < 512; i++) seen[i] = 1'b0;
      seen[0] = 1'b1;
      en[0] = 1'b1;
      for (int s = 1; s <= 511; s++) begin
        @(negedge clk);
        mq[0] = lfsr_next(mq[0]);
        if (s <= 6) check("seq_first", 0, q[0], first[s-1]);
        check("seq_model", 0, q[0], mq[0]);
        if (s < 511) begin
          check("seq_no_repeat", 0, seen[q[0]], 0);
          seen[q[0]] = 1'b1;
        end
      end
      check("seq_period", 0, q[0], 9'h000);
      en[0] = 1'b0;
    end

    // Single draw from reset with defaults.
    do_reset(0);
    run_draw(0, 1'b0, -1, 9'h000, 1'b0, v, m);
    check("dflt_value", 0, value[0], 2'd0);
    check("dflt_miss", 0, miss[0], 0);
    check("dflt_q", 0, q[0], 9'h001);

    // RANGE=3 with three rejections before accept.
    load_seed(1, 9'h007);
    run_draw(1, 1'b0, -1, 9'h000, 1'b0, v, m);
    check("r3_value", 1, value[1], 2'd2);
    check("r3_miss", 1, miss[1], 0);
    check("r3_q", 1, q[1], 9'h07C);

    // MAX_TRIES=2 exhausts, Req held retriggers.
    load_seed(2, 9'h007);
    run_draw(2, 1'b0, -1, 9'h000, 1'b1, v, m);
    check("mt2_value", 2, value[2], 2'd0);
    check("mt2_miss", 2, miss[2], 1);
    run_draw(2, 1'b0, -1, 9'h000, 1'b0, v, m);
    check("mt2_retrig_value", 2, value[2], 2'd2);
    check("mt2_retrig_miss", 2, miss[2], 0);

    // All-ones seed.
    load[0] = 1'b1; seed_in[0] = 9'h1FF;
    @(negedge clk);
    load[0] = 1'b0;
`ifdef LFSR_LOCK_RECOVER_EN
    check("lock_q", 0, q[0], 9'h000);
    check("lock_err_pulse", 0, lock_err[0], 1);
    @(negedge clk);
    check("lock_err_clear", 0, lock_err[0], 0);
    check("lock_q_hold", 0, q[0], 9'h000);
    mq[0] = 9'h000;
`else
    check("lock_q", 0, q[0], 9'h1FF);
    check("lock_err_zero", 0, lock_err[0], 0);
    en[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_stuck", 0, q[0], 9'h1FF);
      check("lock_err_zero", 0, lock_err[0], 0);
    end
    en[0] = 1'b0;
    load_seed(0, 9'h000);
`endif

    // Asynchronous reset in the middle of a draw.
    load_seed(1, 9'h007);
    req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    check("mid_busy_before", 1, busy[1], 1);
    #2 rst[1] = 1'b1;
    #1;
    check("mid_rst_busy", 1, busy[1], 0);
    check("mid_rst_ack", 1, ack[1], 0);
    check("mid_rst_value", 1, value[1], 0);
    check("mid_rst_q", 1, q[1], 9'h000);
    #1 rst[1] = 1'b0;
    mq[1] = 9'h000; last_val[1] = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_no_ack", 1, ack[1], 0);
      check("mid_q", 1, q[1], 9'h000);
    end

    // Randomized mix of free-run, loads and draws (some with a Load mid-draw).
    for (int t = 0; t < 80; t++) begin
      int idx;
      int ldk;
      idx = int'($urandom % 3);
      run_free(idx, 1 + int'($urandom % 6));
      ldk = ($urandom % 4 == 0) ? int'($urandom % max_tries[idx]) : -1;
      run_draw(idx, 1'($urandom % 2), ldk, 9'($urandom % 511), 1'b0, v, m);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
